// File: rtl/lb_scope_capture.sv
`default_nettype none
// ============================================================================
// Module      : lb_scope_capture
// Description : Triggered pre/post waveform capture into a circular RAM on
//               the local bus. Captured window is read back trigger-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module lb_scope_capture #(
    parameter int BUF_AW = 13,
    parameter int DW     = 16
) (
    input  logic              lb_clk,
    input  logic              rst,
    input  logic [DW-1:0]     adc_data,
    input  logic              adc_valid,
    input  logic              ext_trig,
    input  logic              lb_strobe,
    input  logic              lb_write,
    input  logic              lb_rd,
    input  logic [BUF_AW:0]   lb_addr,
    input  logic [31:0]       lb_data,
    output logic [31:0]       lb_dout,
    output logic              lb_rd_valid,
    output logic              done
);

    localparam int c_DEPTH = 2**BUF_AW;

    localparam logic [BUF_AW-1:0] c_ONE  = {{(BUF_AW-1){1'b0}}, 1'b1};
    localparam logic [BUF_AW-1:0] c_ZERO = '0;
    localparam logic [BUF_AW-1:0] c_PTR_MAX = '1;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PRE  = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_POST = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [1:0] c_REG_CTRL    = 2'd0;
    localparam logic [1:0] c_REG_PRETRIG = 2'd1;
    localparam logic [1:0] c_REG_CONFIG  = 2'd2;
    localparam logic [1:0] c_REG_STATUS  = 2'd3;

    // Capture state
    logic [2:0]        r_state;
    logic [BUF_AW-1:0] r_wr_ptr;
    logic [BUF_AW-1:0] r_start_ptr;
    logic [BUF_AW-1:0] r_pre_cnt;
    logic [BUF_AW-1:0] r_post_cnt;
    logic [BUF_AW-1:0] r_pretrig_act;
    logic              r_trig_pend;
    logic              r_done;
    logic [DW-1:0]     r_prev_sample;
    logic              r_ext_d;

    // Software-visible configuration
    logic [BUF_AW-1:0] r_pretrig;
    logic [DW-1:0]     r_threshold;
    logic              r_trig_src;

    // Sample buffer and read pipeline
    logic [DW-1:0]     r_mem [c_DEPTH];
    logic [DW-1:0]     r_ram_q;
    logic              r_rd_v1;
    logic              r_rd_reg1;
    logic [1:0]        r_rd_sel1;
    logic              r_rd_valid;
    logic [31:0]       r_lb_dout;

    logic              w_reg_wr;
    logic              w_ctrl_wr;
    logic              w_arm;
    logic              w_abort;
    logic              w_soft;
    logic              w_busy;
    logic              w_wr_en;
    logic              w_ext_rise;
    logic              w_thr_cross;
    logic              w_trig;
    logic [BUF_AW-1:0] w_start_next;
    logic [BUF_AW-1:0] w_post_init;
    logic              w_rd_req;
    logic [BUF_AW-1:0] w_rd_ptr;
    logic [31:0]       w_reg_rdata;
    logic [31:0]       w_ram_sext;
    logic              w_unused_data;

    // Reserved CONFIG bits are write-ignored.
    assign w_unused_data = &{1'b0, lb_data[30:DW]};

    // Bus decode. Abort dominates arm, and arm swallows a soft trigger in
    // the same write because the capture restarts outside WAIT.
    assign w_reg_wr  = lb_strobe & lb_write & lb_addr[BUF_AW];
    assign w_ctrl_wr = w_reg_wr & (lb_addr[1:0] == c_REG_CTRL);
    assign w_abort   = w_ctrl_wr & lb_data[2];
    assign w_arm     = w_ctrl_wr & lb_data[0] & ~lb_data[2];
    assign w_soft    = w_ctrl_wr & lb_data[1] & ~lb_data[0] & ~lb_data[2];

    assign w_busy = (r_state == c_ST_PRE) || (r_state == c_ST_WAIT) ||
                    (r_state == c_ST_POST);

    // A sample arriving alongside arm/abort is not stored: the pointer is
    // being restarted or the capture is being dropped.
    assign w_wr_en = adc_valid & w_busy & ~w_arm & ~w_abort;

    // Trigger qualification for the sample presented this cycle.
    assign w_ext_rise  = ext_trig & ~r_ext_d;
    assign w_thr_cross = ($signed(r_prev_sample) < $signed(r_threshold)) &&
                         ($signed(r_threshold) <= $signed(adc_data));
    assign w_trig      = r_trig_pend | (~r_trig_src & w_ext_rise) |
                         (r_trig_src & w_thr_cross);

    // Window start and remaining post-trigger samples, mod DEPTH.
    assign w_start_next = r_wr_ptr - r_pretrig_act;
    assign w_post_init  = c_PTR_MAX - r_pretrig_act;

    assign w_rd_req = lb_strobe & lb_rd;
    assign w_rd_ptr = r_start_ptr + lb_addr[BUF_AW-1:0];

    assign w_ram_sext = {{(32-DW){r_ram_q[DW-1]}}, r_ram_q};

    // Capture FSM: pointers, counters, trigger bookkeeping and done flag.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_wr_ptr      <= '0;
            r_start_ptr   <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_pretrig_act <= '0;
            r_trig_pend   <= 1'b0;
            r_done        <= 1'b0;
            r_prev_sample <= '0;
            r_ext_d       <= 1'b0;
        end else begin
            r_ext_d <= ext_trig;
            if (adc_valid) begin
                r_prev_sample <= adc_data;
            end

            if (w_abort) begin
                r_state     <= c_ST_IDLE;
                r_done      <= 1'b0;
                r_trig_pend <= 1'b0;
            end else if (w_arm) begin
                r_wr_ptr      <= '0;
                r_pre_cnt     <= r_pretrig;
                r_pretrig_act <= r_pretrig;
                r_done        <= 1'b0;
                r_trig_pend   <= 1'b0;
                r_state       <= (r_pretrig == c_ZERO) ? c_ST_WAIT : c_ST_PRE;
            end else begin
                case (r_state)
                    c_ST_PRE: begin
                        if (adc_valid) begin
                            r_wr_ptr  <= r_wr_ptr + c_ONE;
                            r_pre_cnt <= r_pre_cnt - c_ONE;
                            if (r_pre_cnt == c_ONE) begin
                                r_state <= c_ST_WAIT;
                            end
                        end
                    end
                    c_ST_WAIT: begin
                        if (adc_valid && w_trig) begin
                            r_wr_ptr    <= r_wr_ptr + c_ONE;
                            r_start_ptr <= w_start_next;
                            r_post_cnt  <= w_post_init;
                            r_trig_pend <= 1'b0;
                            if (w_post_init == c_ZERO) begin
                                r_state <= c_ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= c_ST_POST;
                            end
                        end else begin
                            if (adc_valid) begin
                                r_wr_ptr <= r_wr_ptr + c_ONE;
                            end
                            if (w_soft) begin
                                r_trig_pend <= 1'b1;
                            end
                        end
                    end
                    c_ST_POST: begin
                        if (adc_valid) begin
                            r_wr_ptr   <= r_wr_ptr + c_ONE;
                            r_post_cnt <= r_post_cnt - c_ONE;
                            if (r_post_cnt == c_ONE) begin
                                r_state <= c_ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // PRETRIG and CONFIG registers; PRETRIG is only sampled by arm.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst) begin
            r_pretrig   <= '0;
            r_threshold <= '0;
            r_trig_src  <= 1'b0;
        end else if (w_reg_wr) begin
            if (lb_addr[1:0] == c_REG_PRETRIG) begin
                r_pretrig <= lb_data[BUF_AW-1:0];
            end
            if (lb_addr[1:0] == c_REG_CONFIG) begin
                r_threshold <= lb_data[DW-1:0];
                r_trig_src  <= lb_data[31];
            end
        end
    end

    // Sample RAM: one write port from capture, synchronous read port for the bus.
    always_ff @(posedge lb_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
        if (w_rd_req) begin
            r_ram_q <= r_mem[w_rd_ptr];
        end
    end

    // Register readback mux, evaluated in the second read stage.
    always_comb begin
        w_reg_rdata = '0;
        case (r_rd_sel1)
            c_REG_PRETRIG: begin
                w_reg_rdata[BUF_AW-1:0] = r_pretrig;
            end
            c_REG_CONFIG: begin
                w_reg_rdata[DW-1:0] = r_threshold;
                w_reg_rdata[31]     = r_trig_src;
            end
            c_REG_STATUS: begin
                w_reg_rdata[0]             = w_busy;
                w_reg_rdata[1]             = r_done;
                w_reg_rdata[4:2]           = r_state;
                w_reg_rdata[16 +: BUF_AW]  = r_start_ptr;
            end
            default: begin
                w_reg_rdata = '0;
            end
        endcase
    end

    // Two-stage read pipeline; reset kills any read in flight.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst) begin
            r_rd_v1    <= 1'b0;
            r_rd_reg1  <= 1'b0;
            r_rd_sel1  <= '0;
            r_rd_valid <= 1'b0;
            r_lb_dout  <= '0;
        end else begin
            r_rd_v1    <= w_rd_req;
            r_rd_reg1  <= lb_addr[BUF_AW];
            r_rd_sel1  <= lb_addr[1:0];
            r_rd_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_lb_dout <= r_rd_reg1 ? w_reg_rdata : w_ram_sext;
            end
        end
    end

    assign lb_dout     = r_lb_dout;
    assign lb_rd_valid = r_rd_valid;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lb_scope_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_lb_scope_capture
// Description : Self-checking bench: table-driven buffer/register reads with a
//               read scoreboard, plus hand-written control sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lb_scope_capture;

    localparam int BUF_AW = 4;
    localparam int DW     = 16;

    localparam logic [4:0] c_A_CTRL = 5'd16;
    localparam logic [4:0] c_A_PRE  = 5'd17;
    localparam logic [4:0] c_A_CFG  = 5'd18;
    localparam logic [4:0] c_A_STAT = 5'd19;

    logic              lb_clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     adc_data;
    logic              adc_valid;
    logic              ext_trig;
    logic              lb_strobe;
    logic              lb_write;
    logic              lb_rd;
    logic [BUF_AW:0]   lb_addr;
    logic [31:0]       lb_data;
    logic [31:0]       lb_dout;
    logic              lb_rd_valid;
    logic              done;

    lb_scope_capture #(.BUF_AW(BUF_AW), .DW(DW)) dut (
        .lb_clk      (lb_clk),
        .rst         (rst),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .ext_trig    (ext_trig),
        .lb_strobe   (lb_strobe),
        .lb_write    (lb_write),
        .lb_rd       (lb_rd),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .lb_dout     (lb_dout),
        .lb_rd_valid (lb_rd_valid),
        .done        (done)
    );

    always #5 lb_clk = ~lb_clk;

    int cyc = 0;
    always @(posedge lb_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int          phase;
        string       name;
        logic [4:0]  addr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    // Stimulus generator state
    bit ramp_on   = 0;
    int ramp_val  = 0;
    int ramp_step = 1;
    bit gap_en    = 0;
    int gap_cnt   = 0;
    bit ext_en    = 0;
    int ext_a = 0, ext_b = 0, ext_c = 1000;

    // Read scoreboard: each read must return exactly 2 cycles after issue.
    always @(negedge lb_clk) begin
        sb_t e;
        if (lb_rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: lb_rd_valid=1 data=0x%08h at cycle %0d, required no valid", lb_dout, cyc);
            end else begin
                e = sb.pop_front();
                if (lb_dout !== e.exp || cyc != e.due) begin
                    failures++;
                    $display("FAIL rd %s: got 0x%08h at cycle %0d, required 0x%08h at cycle %0d",
                             e.name, lb_dout, cyc, e.exp, e.due);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL rd %s: no lb_rd_valid at cycle %0d, required 0x%08h", e.name, cyc, e.exp);
        end
    end

    task automatic add(int ph, string n, logic [4:0] a, logic [31:0] e);
        vec_t v;
        v.phase = ph; v.name = n; v.addr = a; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and present the next ADC sample (or a gap).
    task automatic step();
        @(posedge lb_clk);
        #1;
        if (!ramp_on || !ext_en) ext_trig = 1'b0;
        if (ramp_on && !(gap_en && (gap_cnt % 3 == 2))) begin
            adc_valid = 1'b1;
            adc_data  = ramp_val[DW-1:0];
            if (ext_en)
                ext_trig = ((ramp_val >= ext_a && ramp_val < ext_b) || ramp_val >= ext_c);
            ramp_val += ramp_step;
        end else begin
            adc_valid = 1'b0;
        end
        gap_cnt++;
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        lb_strobe = 1'b1; lb_write = 1'b1; lb_rd = 1'b0; lb_addr = a; lb_data = d;
        step();
        lb_strobe = 1'b0; lb_write = 1'b0;
    endtask

    // Issues one read and leaves the strobe up so calls chain back-to-back.
    task automatic rd(logic [4:0] a, logic [31:0] exp, string name);
        sb_t e;
        lb_strobe = 1'b1; lb_rd = 1'b1; lb_write = 1'b0; lb_addr = a;
        e.exp = exp; e.due = cyc + 2; e.name = name;
        sb.push_back(e);
        step();
    endtask

    task automatic drain();
        int n = 0;
        lb_strobe = 1'b0; lb_rd = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic apply_phase(int ph);
        foreach (tbl[i]) begin
            if (tbl[i].phase == ph) rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
        end
        drain();
    endtask

    task automatic wait_val(int v);
        int n = 0;
        while (!(adc_valid && adc_data == v[DW-1:0]) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL wait_sample: sample %0d never presented", v);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_done: done=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic start_ramp(int start, int stp);
        ramp_val = start; ramp_step = stp; ramp_on = 1'b1; gap_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected read-back tables
        for (int i = 0; i < 16; i++) add(1, "soft_off", 5'(i), 32'(6 + i));
        add(1, "soft_status", c_A_STAT, 32'h0006_0012);

        add(2, "thr_off0",   5'd0,  32'd80);
        add(2, "thr_off1",   5'd1,  32'd90);
        add(2, "thr_off2",   5'd2,  32'd100);
        add(2, "thr_off9",   5'd9,  32'd170);
        add(2, "thr_off15",  5'd15, 32'd230);
        add(2, "thr_status", c_A_STAT, 32'h0008_0012);

        add(3, "ext_off0",   5'd0,  32'd7);
        add(3, "ext_off3",   5'd3,  32'd10);
        add(3, "ext_off15",  5'd15, 32'd22);
        add(3, "ext_status", c_A_STAT, 32'h0007_0012);

        add(4, "ext0_off0",   5'd0,  32'd5);
        add(4, "ext0_off1",   5'd1,  32'd6);
        add(4, "ext0_off15",  5'd15, 32'd20);
        add(4, "ext0_status", c_A_STAT, 32'h0005_0012);

        add(6, "rearm_off0",   5'd0,  32'd12);
        add(6, "rearm_off2",   5'd2,  32'd18);
        add(6, "rearm_off15",  5'd15, 32'd57);
        add(6, "rearm_status", c_A_STAT, 32'h0004_0012);
        add(6, "rearm_pretrig", c_A_PRE, 32'd9);

        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; ext_trig = 1'b0;
        lb_strobe = 1'b0; lb_write = 1'b0; lb_rd = 1'b0; lb_addr = '0; lb_data = '0;
        repeat (3) step();
        chk("reset_dout",  lb_dout, 32'h0);
        chk("reset_valid", {31'h0, lb_rd_valid}, 32'h0);
        chk("reset_done",  {31'h0, done}, 32'h0);
        rst = 1'b0;
        step();
        rd(c_A_STAT, 32'h0, "reset_status");
        rd(c_A_PRE,  32'h0, "reset_pretrig");
        rd(c_A_CFG,  32'h0, "reset_config");
        drain();

        // Soft trigger, PRETRIG=4
        wr(c_A_PRE, 32'd4);
        wr(c_A_CFG, 32'h0);
        rd(c_A_PRE, 32'd4, "pretrig_rw");
        drain();
        start_ramp(0, 1);
        wr(c_A_CTRL, 32'h1);
        wait_val(9);
        wr(c_A_CTRL, 32'h2);
        wait_val(21);
        chk("soft_done_before_last", {31'h0, done}, 32'h0);
        step();
        chk("soft_done_after_last", {31'h0, done}, 32'h1);
        repeat (3) step();
        apply_phase(1);
        ramp_on = 1'b0;
        step();

        // Threshold crossing, step 10, PRETRIG=2
        wr(c_A_PRE, 32'd2);
        wr(c_A_CFG, 32'h8000_0064);
        rd(c_A_CFG, 32'h8000_0064, "config_rw");
        drain();
        start_ramp(0, 10);
        wr(c_A_CTRL, 32'h1);
        wait_done();
        ramp_on = 1'b0;
        apply_phase(2);

        // External edge: PRE edge ignored, level ignored, second edge triggers
        wr(c_A_PRE, 32'd3);
        wr(c_A_CFG, 32'h0);
        ext_en = 1'b1; ext_a = 1; ext_b = 8; ext_c = 10;
        start_ramp(0, 1);
        wr(c_A_CTRL, 32'h1);
        wait_val(4);
        rd(c_A_STAT, 32'h0008_0009, "ext_wait_status");
        rd(5'd0, 32'd80, "read_during_capture");
        drain();
        wait_done();
        ramp_on = 1'b0;
        apply_phase(3);

        // PRETRIG=0 with adc_valid gaps
        wr(c_A_PRE, 32'd0);
        ext_a = 0; ext_b = 0; ext_c = 5;
        gap_en = 1'b1;
        start_ramp(0, 1);
        wr(c_A_CTRL, 32'h1);
        wait_done();
        ramp_on = 1'b0; gap_en = 1'b0; ext_en = 1'b0;
        apply_phase(4);

        // Abort during POST, then arm+abort in one write
        wr(c_A_PRE, 32'd4);
        start_ramp(0, 1);
        wr(c_A_CTRL, 32'h1);
        wait_val(6);
        wr(c_A_CTRL, 32'h2);
        wait_val(9);
        wr(c_A_CTRL, 32'h4);
        chk("abort_done", {31'h0, done}, 32'h0);
        rd(c_A_STAT, 32'h0003_0000, "abort_status");
        drain();
        wr(c_A_CTRL, 32'h1);
        step();
        wr(c_A_CTRL, 32'h5);
        rd(c_A_STAT, 32'h0003_0000, "arm_abort_status");
        drain();
        ramp_on = 1'b0;
        step();

        // Reset mid-POST with a read in flight
        start_ramp(0, 1);
        wr(c_A_CTRL, 32'h1);
        wait_val(6);
        wr(c_A_CTRL, 32'h2);
        wait_val(9);
        lb_strobe = 1'b1; lb_rd = 1'b1; lb_addr = 5'd0;
        step();
        lb_strobe = 1'b0; lb_rd = 1'b0;
        rst = 1'b1; ramp_on = 1'b0; adc_valid = 1'b0;
        #1;
        chk("rst_dout",  lb_dout, 32'h0);
        chk("rst_valid", {31'h0, lb_rd_valid}, 32'h0);
        chk("rst_done",  {31'h0, done}, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        step();
        rd(c_A_PRE,  32'h0, "rst_pretrig");
        rd(c_A_CFG,  32'h0, "rst_config");
        rd(c_A_STAT, 32'h0, "rst_status");
        drain();

        // Re-arm after reset; PRETRIG rewritten while busy must not apply
        wr(c_A_PRE, 32'd2);
        start_ramp(0, 3);
        wr(c_A_CTRL, 32'h1);
        wr(c_A_PRE, 32'd9);
        wait_val(15);
        wr(c_A_CTRL, 32'h2);
        wait_done();
        ramp_on = 1'b0;
        apply_phase(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lb_scope_capture.md
Name: lb_scope_capture

Overview:
- Triggered waveform capture buffer for the oscope application; it sits directly on the marble_base local bus in the lb_clk domain.
- Takes one ADC sample stream that has already been moved into lb_clk and carries a valid strobe.
- Records a pre-/post-trigger window into a circular RAM, then lets host software read the window back over the local bus, trigger-aligned.

Parameters:
- BUF_AW, 13, buffer address width; DEPTH = 2**BUF_AW samples.
- DW, 16, sample width, signed two's complement.

Ports:
- lb_clk  input  1  sole clock
- rst  input  1  asynchronous, active-high reset
- adc_data  input  DW  signed sample
- adc_valid  input  1  sample qualifier
- ext_trig  input  1  external trigger level, already synchronous to lb_clk
- lb_strobe  input  1  bus cycle qualifier
- lb_write  input  1  write cycle
- lb_rd  input  1  read cycle
- lb_addr  input  BUF_AW+1  [BUF_AW]=1 selects registers, 0 selects buffer
- lb_data  input  32  write data
- lb_dout  output  32  read data
- lb_rd_valid  output  1  read data qualifier
- done  output  1  capture complete, level

Behaviour:
- Register map, selected when lb_addr[BUF_AW]=1, decoded on lb_addr[1:0]:
  - 0 CTRL (write-only pulses):
    - bit0 arm
    - bit1 soft_trig
    - bit2 abort
  - 1 PRETRIG (R/W, BUF_AW bits, reset 0).
  - 2 CONFIG (R/W, reset 0):
    - [DW-1:0] threshold, signed
    - bit31 trig_src: 0 = ext_trig rising edge, 1 = threshold crossing
  - 3 STATUS (RO):
    - bit0 busy
    - bit1 done
    - [4:2] state: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4
    - [16+BUF_AW-1:16] start_ptr
- Buffer read: data at RAM[(start_ptr + lb_addr[BUF_AW-1:0]) mod DEPTH], sign-extended to 32 bits.
- Read latency:
  - lb_rd_valid pulses exactly 2 cycles after a cycle with lb_strobe&lb_rd; lb_dout is valid in that cycle.
  - Reads may be issued back-to-back, one per cycle.
  - lb_dout holds its last value otherwise.
- Reset values: state IDLE, wr_ptr=0, start_ptr=0, post_cnt=0, trig_pend=0, lb_dout=0, lb_rd_valid=0, done=0, PRETRIG=0, CONFIG=0. RAM contents are undefined.
- FSM, one sample written per adc_valid in PRE/WAIT/POST; each write increments wr_ptr with wrap at DEPTH:
  - IDLE/DONE + arm -> PRE. wr_ptr=0, pre_cnt=PRETRIG, done=0.
  - PRE: decrement pre_cnt per sample. When pre_cnt reaches 0 -> WAIT; if PRETRIG=0, go directly to WAIT. Triggers in PRE are ignored and not remembered.
  - WAIT: writes wrap freely. The trigger sample is the first valid sample for which trigger is true:
    - trig_pend set, or
    - trig_src=0 and ext_trig rose since the previous cycle (edge detect registered every cycle), or
    - trig_src=1 and prev_sample < threshold <= adc_data.
    - prev_sample updates on every adc_valid in all states.
  - On the trigger sample:
    - start_ptr <= (wr_ptr - PRETRIG) mod DEPTH
    - the sample is written at wr_ptr
    - post_cnt <= DEPTH - PRETRIG - 1
    - -> POST, or DONE directly if post_cnt would be 0.
  - POST: decrement post_cnt per sample; written sample with post_cnt=0 -> DONE.
  - DONE: done=1, no writes.
- soft_trig: sets trig_pend only in WAIT; it is consumed by the trigger sample. trig_pend is cleared on leaving WAIT.
- abort, in any state: -> IDLE, done=0. abort wins over arm in the same write.
- arm while busy: restart from PRE (same as from IDLE).
- arm and soft_trig in the same write: arm acts, soft_trig is discarded (state was not WAIT).
- PRETRIG writes while busy: latched value takes effect at the next arm only.
- Buffer reads during capture are legal and return current RAM contents, with no effect on capture.
- rst mid-operation: immediate return to reset values. Any read in flight produces no lb_rd_valid.

Test Plan:
All cases use BUF_AW=4 (DEPTH 16), DW=16, and a continuous adc_valid ramp with sample n = n unless stated.
- Soft trigger: PRETRIG=4, arm, soft_trig written after sample 9 -> trigger sample 10, STATUS start_ptr=6, offsets 0..15 read 6..21, done rises after sample 21, no further writes.
- Threshold: trig_src=1, threshold=100, ramp step 10 from 0, PRETRIG=2 -> trigger on 100 (prev 90); offset0=80, offset2=100, offset15=230.
- External trigger:
  - an ext_trig edge during PRE is ignored;
  - a level held high does not trigger;
  - the next low->high edge triggers on the next valid sample;
  - PRETRIG=0 -> offset0 is the trigger sample.
- Timing:
  - lb_rd_valid exactly 2 cycles after strobe;
  - 4 back-to-back reads give 4 consecutive valid pulses with correct data;
  - adc_valid gaps stall counters without loss.
- Control:
  - abort during POST -> STATUS state 0, done=0;
  - arm+abort in the same write -> IDLE;
  - rst asserted mid-POST -> all outputs 0, and a re-arm captures correctly.
